hangman_ctrl_p: RTL and testbench

Parametrised control FSM for the hangman game: counts word characters as the setter loads them, sequences guess/compare/fill/draw turns against the datapath, enforces a per-turn timeout, and keeps saturating scores for setter and guesser across rounds. It sits between the keyboard strobes and the word-register/comparator/VGA-drawing datapath and replaces the fixed-size controller with configurable word length, miss limit and turn time.

---
 rtl/hangman_ctrl_p.sv | 181 ++++++++++++++++++
 tb/tb_hangman_ctrl_p.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_ctrl_p.sv
// Hangman round controller: counts word characters, sequences guess/compare/fill/draw
// turns, enforces a per-turn timeout and keeps saturating scores across rounds.
// Latency: try->compare 1 cycle, compare->fill/draw 1 cycle, back to play 1 cycle.
// Backpressure: none; strobes are level inputs sampled only in the states that use them.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   load, endinput               setter character strobe / word finished
//   start, try, wipe             begin guessing / submit guess / next round
//   match, hit_count             datapath compare result, used only in COMPARE
//   ld..won                      Moore strobes decoded from the registered state
//   word_len, remaining, part    word length, hidden characters, body parts drawn
//   timer                        cycles left in the current turn
//   p1score, p2score             setter / guesser saturating scores
module hangman_ctrl_p #(
  parameter int MAX_LEN     = 16,
  parameter int MAX_MISS    = 9,
  parameter int TURN_CYCLES = 50000000,
  parameter int SCORE_W     = 4,
  localparam int LEN_W      = $clog2(MAX_LEN + 1),
  localparam int MISS_W     = $clog2(MAX_MISS + 1),
  localparam int TIMER_W    = $clog2(TURN_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               endinput,
  input  logic               start,
  input  logic               try,
  input  logic               wipe,
  input  logic               match,
  input  logic [LEN_W-1:0]   hit_count,
  output logic               ld,
  output logic               timecount,
  output logic               compare,
  output logic               fill,
  output logic               draw,
  output logic               over,
  output logic               won,
  output logic [LEN_W-1:0]   word_len,
  output logic [LEN_W-1:0]   remaining,
  output logic [MISS_W-1:0]  part,
  output logic [TIMER_W-1:0] timer,
  output logic [SCORE_W-1:0] p1score,
  output logic [SCORE_W-1:0] p2score
);

  typedef enum logic [3:0] {
    S_LOAD,
    S_LOAD_WAIT,
    S_READY,
    S_PLAY,
    S_COMPARE,
    S_FILL,
    S_DRAW,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MAX_MISS);
  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t state;

  // A repeated letter can report more hits than characters still hidden;
  // clamp so remaining never wraps.
  logic [LEN_W-1:0] reveal;
  assign reveal = (hit_count > remaining) ? remaining : hit_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_LOAD;
      word_len  <= '0;
      remaining <= '0;
      part      <= '0;
      timer     <= '0;
      p1score   <= '0;
      p2score   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          // load has priority over endinput when both are seen together
          if (load) begin
            state <= S_LOAD_WAIT;
            if (word_len != LEN_MAX) word_len <= word_len + 1'b1;
          end else if (endinput && (word_len != '0)) begin
            state     <= S_READY;
            remaining <= word_len;
            part      <= '0;
          end
        end
        S_LOAD_WAIT: begin
          // one increment per key press: wait for release
          if (!load) state <= S_LOAD;
        end
        S_READY: begin
          if (start) begin
            state <= S_PLAY;
            timer <= TURN_LOAD;
          end
        end
        S_PLAY: begin
          // the timeout is checked before try so a late guess still loses
          if (timer == '0) begin
            state <= S_LOSE;
            if (p1score != SCORE_MAX) p1score <= p1score + 1'b1;
          end else begin
            timer <= timer - 1'b1;
            if (try) state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          // a match that reveals nothing new is a repeated letter: costs a part
          if (match && (hit_count != '0)) begin
            state     <= S_FILL;
            remaining <= remaining - reveal;
          end else begin
            state <= S_DRAW;
            if (part != MISS_MAX) part <= part + 1'b1;
          end
        end
        S_FILL: begin
          if (remaining == '0) begin
            state <= S_WIN;
            if (p2score != SCORE_MAX) p2score <= p2score + 1'b1;
          end else begin
            state <= S_PLAY;
            timer <= TURN_LOAD;
          end
        end
        S_DRAW: begin
          if (part == MISS_MAX) begin
            state <= S_LOSE;
            if (p1score != SCORE_MAX) p1score <= p1score + 1'b1;
          end else begin
            state <= S_PLAY;
            timer <= TURN_LOAD;
          end
        end
        S_WIN, S_LOSE: begin
          // scores persist across rounds; everything else starts fresh
          if (wipe) begin
            state     <= S_LOAD;
            word_len  <= '0;
            remaining <= '0;
            part      <= '0;
            timer     <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Moore strobes: a pure decode of the registered state
  always_comb begin
    ld        = 1'b0;
    timecount = 1'b0;
    compare   = 1'b0;
    fill      = 1'b0;
    draw      = 1'b0;
    over      = 1'b0;
    won       = 1'b0;
    case (state)
      S_LOAD:    ld        = 1'b1;
      S_PLAY:    timecount = 1'b1;
      S_COMPARE: compare   = 1'b1;
      S_FILL:    fill      = 1'b1;
      S_DRAW:    draw      = 1'b1;
      S_WIN: begin
        over = 1'b1;
        won  = 1'b1;
      end
      S_LOSE:    over      = 1'b1;
      default:   ld        = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hangman_ctrl_p.sv
module tb_hangman_ctrl_p;

  localparam int MAX_LEN  = 16;
  localparam int MAX_MISS = 9;
  localparam int T        = 20;
  localparam int SCORE_W  = 4;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);
  localparam int MISS_W   = $clog2(MAX_MISS + 1);
  localparam int TIMER_W  = $clog2(T + 1);
  localparam int SMAX     = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               resetn;
  logic               load, endinput, start, try, wipe, match;
  logic [LEN_W-1:0]   hit_count;
  logic               ld, timecount, compare, fill, draw, over, won;
  logic [LEN_W-1:0]   word_len, remaining;
  logic [MISS_W-1:0]  part;
  logic [TIMER_W-1:0] timer;
  logic [SCORE_W-1:0] p1score, p2score;

  hangman_ctrl_p #(
    .MAX_LEN(MAX_LEN), .MAX_MISS(MAX_MISS), .TURN_CYCLES(T), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .resetn(resetn), .load(load), .endinput(endinput), .start(start),
    .try(try), .wipe(wipe), .match(match), .hit_count(hit_count),
    .ld(ld), .timecount(timecount), .compare(compare), .fill(fill), .draw(draw),
    .over(over), .won(won), .word_len(word_len), .remaining(remaining), .part(part),
    .timer(timer), .p1score(p1score), .p2score(p2score)
  );

  always #5 clk = ~clk;

  // reference game state, kept in whole-game terms
  int vectors = 0;
  int miscompares = 0;
  int exp_p1 = 0, exp_p2 = 0;
  int exp_len = 0, exp_rem = 0, exp_part = 0;
  int outcome = 0;  // 0 still playing, 1 guesser won, 2 setter won

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SMAX) ? SMAX : v + 1;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ld"}, 32'(ld), 1);
    chk({tag, "_strobes"}, 32'({timecount, compare, fill, draw, over, won}), 0);
    chk({tag, "_word_len"}, 32'(word_len), 0);
    chk({tag, "_remaining"}, 32'(remaining), 0);
    chk({tag, "_part"}, 32'(part), 0);
    chk({tag, "_timer"}, 32'(timer), 0);
    chk({tag, "_p1"}, 32'(p1score), 0);
    chk({tag, "_p2"}, 32'(p2score), 0);
  endtask

  task automatic press(input int hold);
    load = 1'b1;
    step();
    exp_len = (exp_len + 1 > MAX_LEN) ? MAX_LEN : exp_len + 1;
    chk("ld_while_held", 32'(ld), 0);
    chk("word_len_press", 32'(word_len), 32'(exp_len));
    repeat (hold - 1) step();
    load = 1'b0;
    step();
    chk("ld_after_release", 32'(ld), 1);
  endtask

  // setter loads n characters, ends the word and the guesser starts
  task automatic setup_round(input int n);
    exp_len = 0;
    for (int i = 0; i < n; i++) press($urandom_range(1, 3));
    endinput = 1'b1;
    step();
    endinput = 1'b0;
    chk("ready_strobes", 32'({ld, timecount, over}), 0);
    chk("ready_word_len", 32'(word_len), 32'(exp_len));
    chk("ready_remaining", 32'(remaining), 32'(exp_len));
    chk("ready_part", 32'(part), 0);
    exp_rem = exp_len;
    exp_part = 0;
    outcome = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("play_entry_timecount", 32'(timecount), 1);
    chk("play_entry_timer", 32'(timer), T);
  endtask

  task automatic win_end();
    exp_p2 = sat_inc(exp_p2);
    chk("win_over", 32'({over, won}), 3);
    chk("win_p2score", 32'(p2score), 32'(exp_p2));
    outcome = 1;
  endtask

  task automatic lose_end();
    exp_p1 = sat_inc(exp_p1);
    chk("lose_over", 32'({over, won}), 2);
    chk("lose_p1score", 32'(p1score), 32'(exp_p1));
    outcome = 2;
  endtask

  // one guess from a freshly entered turn, after 'idle' thinking cycles
  task automatic guess(input int idle, input bit m, input int h);
    int revealed;
    repeat (idle) step();
    chk("turn_timecount", 32'(timecount), 1);
    chk("turn_timer", 32'(timer), 32'(T - idle));
    try = 1'b1;
    step();
    try = 1'b0;
    chk("compare_strobe", 32'({compare, timecount}), 2);
    match = m;
    hit_count = LEN_W'(h);
    step();
    match = 1'b0;
    hit_count = '0;
    if (m && h != 0) begin
      revealed = (h < exp_rem) ? h : exp_rem;
      exp_rem = exp_rem - revealed;
      chk("fill_strobe", 32'({fill, draw}), 2);
      chk("fill_remaining", 32'(remaining), 32'(exp_rem));
      step();
      if (exp_rem == 0) win_end();
      else chk("fill_back_timer", 32'({timecount, timer}), 32'({1'b1, TIMER_W'(T)}));
    end else begin
      exp_part++;
      chk("draw_strobe", 32'({fill, draw}), 1);
      chk("draw_part", 32'(part), 32'(exp_part));
      step();
      if (exp_part == MAX_MISS) lose_end();
      else chk("draw_back_timer", 32'({timecount, timer}), 32'({1'b1, TIMER_W'(T)}));
    end
  endtask

  // stay idle from a fresh turn until the timer expires; optionally try on that cycle
  task automatic timeout_now(input bit with_try);
    repeat (T) step();
    chk("timeout_last_cycle", 32'({timecount, timer}), 32'({1'b1, TIMER_W'(0)}));
    try = with_try;
    step();
    try = 1'b0;
    lose_end();
  endtask

  task automatic wipe_round();
    wipe = 1'b1;
    step();
    wipe = 1'b0;
    chk("wipe_ld", 32'({ld, over}), 2);
    chk("wipe_counters", 32'({word_len, remaining, part, timer}), 0);
    chk("wipe_p1", 32'(p1score), 32'(exp_p1));
    chk("wipe_p2", 32'(p2score), 32'(exp_p2));
  endtask

  initial begin
    int n, guard;
    resetn = 1'b0;
    {load, endinput, start, try, wipe, match} = '0;
    hit_count = '0;
    repeat (2) step();
    check_reset("reset");
    resetn = 1'b1;
    step();

    // empty word cannot be ended
    endinput = 1'b1;
    step();
    endinput = 1'b0;
    chk("empty_endinput_ld", 32'(ld), 1);
    chk("empty_endinput_len", 32'(word_len), 0);

    // four presses held three cycles, then hits of 2,1,1 win the round
    exp_len = 0;
    for (int i = 0; i < 4; i++) press(3);
    endinput = 1'b1;
    step();
    endinput = 1'b0;
    chk("w4_word_len", 32'(word_len), 4);
    chk("w4_remaining", 32'(remaining), 4);
    chk("w4_ready_ld", 32'({ld, timecount}), 0);
    exp_rem = 4; exp_part = 0; outcome = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    guess(2, 1'b1, 2);
    guess(0, 1'b1, 1);
    guess(5, 1'b1, 1);
    chk("w4_outcome", 32'(outcome), 1);
    wipe_round();

    // 20 presses saturate at MAX_LEN; 9 misses, one a repeated letter, lose
    setup_round(20);
    chk("sat_word_len", 32'(word_len), MAX_LEN);
    for (int i = 0; i < MAX_MISS; i++) guess(1, (i == 4), 0);
    chk("miss_outcome", 32'(outcome), 2);
    wipe_round();

    // untouched turn lasts T+1 cycles, then the setter wins
    setup_round(2);
    n = 1;
    guard = 0;
    while (timecount && guard < 100) begin
      step();
      guard++;
      if (timecount) n++;
    end
    chk("timeout_turn_length", 32'(n), T + 1);
    lose_end();
    wipe_round();

    // try on the very cycle the timer expires still loses
    setup_round(3);
    timeout_now(1'b1);
    wipe_round();

    // random rounds against the game model
    for (int r = 0; r < 20; r++) begin
      setup_round($urandom_range(1, 20));
      guard = 0;
      while (outcome == 0 && guard < 100) begin
        guard++;
        if ($urandom_range(0, 9) == 0) timeout_now(1'($urandom % 2));
        else guess($urandom_range(0, 4), 1'($urandom % 2), $urandom_range(0, 3));
      end
      chk("random_round_ended", 32'(outcome != 0), 1);
      wipe_round();
    end

    // 17 quick wins drive the guesser score into saturation
    for (int r = 0; r < 17; r++) begin
      setup_round(1);
      guess(0, 1'b1, 1);
      wipe_round();
    end
    chk("p2score_saturated", 32'(p2score), SMAX);

    // asynchronous reset in the middle of a turn
    setup_round(3);
    repeat (2) step();
    resetn = 1'b0;
    #1;
    check_reset("async_reset");
    exp_p1 = 0;
    exp_p2 = 0;
    #2;
    resetn = 1'b1;
    step();
    chk("post_reset_ld", 32'(ld), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
